// File: rtl/i2s_tdm_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tdm_transmitter
//  Description : Serial audio transmitter supporting I2S, left-justified and
//                TDM framing. One-entry holding register feeds a frame-wide
//                shift image; every output is registered so BCLK, LRCLK/sync
//                and data all move together on the BCLK falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tdm_transmitter #(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 6,
  parameter int MODE         = 0
) (
  input  logic                             clock_16_934_400,
  input  logic                             reset,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_in,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  input  logic                             mute,
  output logic                             i2s_bit_clock,
  output logic                             i2s_left_right_clock,
  output logic                             i2s_data,
  output logic                             frame_start,
  output logic [15:0]                      underrun_count
);

  localparam int c_FRAME_BITS = CHANNELS * SLOT_WIDTH;
  localparam int c_DIV_W      = $clog2(BCLK_DIV);
  localparam int c_B_W        = $clog2(c_FRAME_BITS);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(BCLK_DIV / 2);
  localparam logic [c_B_W-1:0]   c_B_LAST   = c_B_W'(c_FRAME_BITS - 1);
  localparam logic [c_B_W-1:0]   c_SLOT_B   = c_B_W'(SLOT_WIDTH);
  localparam logic [15:0]        c_UND_MAX  = 16'hFFFF;

  // The internal counters run one clock ahead of the pins: the output
  // registers sample (r_div, r_b) and present them on the following clock.
  logic [c_DIV_W-1:0]               r_div;
  logic [c_B_W-1:0]                 r_b;
  logic [CHANNELS*SAMPLE_WIDTH-1:0] r_hold;
  logic                             r_full;
  logic                             r_ready;
  logic                             r_armed;
  logic [c_FRAME_BITS-1:0]          r_frame;
  logic [15:0]                      r_underrun;
  logic                             r_bclk;
  logic                             r_lrclk;
  logic                             r_data;
  logic                             r_fs;

  logic                             w_load;
  logic                             w_bit_edge;
  logic                             w_accept;
  logic                             w_full_next;
  logic [c_FRAME_BITS-1:0]          w_packed;
  logic [c_FRAME_BITS-1:0]          w_new_frame;
  logic [c_FRAME_BITS-1:0]          w_src;
  logic [c_B_W-1:0]                 w_idx_msb;
  logic [c_B_W-1:0]                 w_idx_dly;
  logic                             w_data_bit;
  logic                             w_lr_bit;

  // A frame load happens when the bit counter sits at the start of bit 0.
  assign w_load      = (r_div == '0) && (r_b == '0);
  assign w_bit_edge  = (r_div == '0);
  assign w_accept    = sample_valid && r_ready;
  // A sample accepted in the load clock survives the load and waits a frame.
  assign w_full_next = w_accept || (r_full && !w_load);

  // Place each channel left-aligned in its slot, slot 0 at the frame MSB.
  always_comb begin
    w_packed = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_packed[c_FRAME_BITS-1-c*SLOT_WIDTH -: SAMPLE_WIDTH] =
        r_hold[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  // Mute and underrun both produce silence; mute still drains the holding entry.
  assign w_new_frame = (mute || !r_full) ? '0 : w_packed;
  assign w_src       = w_load ? w_new_frame : r_frame;
  assign w_idx_msb   = c_B_LAST - r_b;
  assign w_idx_dly   = w_idx_msb + c_B_W'(1);

  // Select the serial bit and the LRCLK/sync level for the upcoming bit time.
  always_comb begin
    w_data_bit = 1'b0;
    w_lr_bit   = 1'b0;
    case (MODE)
      0: begin
        // I2S: one-bit delay; bit 0 of a frame carries the old frame's last LSB.
        w_data_bit = (r_b == '0) ? r_frame[0] : r_frame[w_idx_dly];
        w_lr_bit   = (r_b >= c_SLOT_B);
      end
      1: begin
        w_data_bit = w_src[w_idx_msb];
        w_lr_bit   = (r_b < c_SLOT_B);
      end
      default: begin
        w_data_bit = w_src[w_idx_msb];
        w_lr_bit   = (r_b == '0);
      end
    endcase
  end

  // Bit-clock divider and frame bit counter.
  always_ff @(posedge clock_16_934_400) begin
    if (reset) begin
      r_div <= '0;
      r_b   <= '0;
    end else begin
      if (r_div == c_DIV_LAST) begin
        r_div <= '0;
        r_b   <= (r_b == c_B_LAST) ? '0 : r_b + c_B_W'(1);
      end else begin
        r_div <= r_div + c_DIV_W'(1);
      end
    end
  end

  // One-entry holding register with its handshake and arming flag.
  always_ff @(posedge clock_16_934_400) begin
    if (reset) begin
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_ready <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold  <= sample_in;
        r_armed <= 1'b1;
      end
      r_full  <= w_full_next;
      r_ready <= !w_full_next;
    end
  end

  // Frame image load and saturating underrun counter.
  always_ff @(posedge clock_16_934_400) begin
    if (reset) begin
      r_frame    <= '0;
      r_underrun <= '0;
    end else if (w_load) begin
      r_frame <= w_new_frame;
      if (!r_full && r_armed && (r_underrun != c_UND_MAX)) begin
        r_underrun <= r_underrun + 16'd1;
      end
    end
  end

  // Registered serial outputs; data and LRCLK only move at the BCLK fall.
  always_ff @(posedge clock_16_934_400) begin
    if (reset) begin
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_data  <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_bclk <= (r_div >= c_DIV_HALF);
      r_fs   <= w_load;
      if (w_bit_edge) begin
        r_data  <= w_data_bit;
        r_lrclk <= w_lr_bit;
      end
    end
  end

  assign sample_ready         = r_ready;
  assign i2s_bit_clock        = r_bclk;
  assign i2s_left_right_clock = r_lrclk;
  assign i2s_data             = r_data;
  assign frame_start          = r_fs;
  assign underrun_count       = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tdm_transmitter
//  Description : Directed self-checking bench; one default I2S instance and
//                one 4-slot TDM instance, each with its own reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (I2S, 2 x 24 in 32-bit slots)
  logic        rst_a, valid_a, mute_a, ready_a, bclk_a, lr_a, data_a, fs_a;
  logic [47:0] sample_a;
  logic [15:0] und_a;
  // TDM instance (4 x 16 in 32-bit slots)
  logic        rst_b, valid_b, mute_b, ready_b, bclk_b, lr_b, data_b, fs_b;
  logic [63:0] sample_b;
  logic [15:0] und_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam logic [63:0]  LR_I2S   = 64'h00000000_FFFFFFFF;
  localparam logic [127:0] LR_TDM   = {1'b1, 127'b0};
  localparam logic [127:0] TDM_DATA = 128'h8001_0000_7FFF_0000_0000_0000_FFFF_0000;
  localparam logic [47:0]  S1       = {24'h800000, 24'h7FFFFF};
  localparam logic [47:0]  S2       = {24'h55AA33, 24'hC3C3C3};
  localparam logic [47:0]  S3       = {24'hFFFFFF, 24'h000000};

  i2s_tdm_transmitter dut (
    .clock_16_934_400    (clk),
    .reset               (rst_a),
    .sample_in           (sample_a),
    .sample_valid        (valid_a),
    .sample_ready        (ready_a),
    .mute                (mute_a),
    .i2s_bit_clock       (bclk_a),
    .i2s_left_right_clock(lr_a),
    .i2s_data            (data_a),
    .frame_start         (fs_a),
    .underrun_count      (und_a)
  );

  i2s_tdm_transmitter #(
    .CHANNELS(4), .SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .BCLK_DIV(6), .MODE(2)
  ) dut_tdm (
    .clock_16_934_400    (clk),
    .reset               (rst_b),
    .sample_in           (sample_b),
    .sample_valid        (valid_b),
    .sample_ready        (ready_b),
    .mute                (mute_b),
    .i2s_bit_clock       (bclk_b),
    .i2s_left_right_clock(lr_b),
    .i2s_data            (data_b),
    .frame_start         (fs_b),
    .underrun_count      (und_b)
  );

  // Expected I2S frame as seen on the pin, first transmitted bit in the MSB.
  function automatic logic [63:0] exp_i2s(input logic [47:0] s);
    return {1'b0, s[23:0], 8'h00, s[47:24], 7'h00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Observe one whole frame starting at its first clock; records data and
  // LRCLK at mid-bit, plus counts of BCLK errors, pulses and handshakes.
  task automatic capture(input int sel, input int nbits, input logic [63:0] nxt,
                         input logic keep_valid,
                         output logic [127:0] d, output logic [127:0] lr,
                         output int bclk_err, output int fs_cnt, output int rdy_cnt,
                         output int acc_cnt, output int lr_hi);
    logic ob, od, ol, ofs, ordy, ov, eb;
    d = '0; lr = '0; bclk_err = 0; fs_cnt = 0; rdy_cnt = 0; acc_cnt = 0; lr_hi = 0;
    for (int c = 0; c < nbits * 6; c++) begin
      if (c == 1) begin
        if (sel == 0) begin
          sample_a = nxt[47:0];
          if (!keep_valid) valid_a = 1'b0;
        end else begin
          sample_b = nxt;
          if (!keep_valid) valid_b = 1'b0;
        end
      end
      if (sel == 0) begin
        ob = bclk_a; od = data_a; ol = lr_a; ofs = fs_a; ordy = ready_a; ov = valid_a;
      end else begin
        ob = bclk_b; od = data_b; ol = lr_b; ofs = fs_b; ordy = ready_b; ov = valid_b;
      end
      eb = ((c % 6) >= 3);
      if (ob !== eb) bclk_err++;
      if ((c % 6) == 3) begin
        d[nbits-1-c/6]  = od;
        lr[nbits-1-c/6] = ol;
      end
      if (ofs === 1'b1) fs_cnt++;
      if (ordy === 1'b1) rdy_cnt++;
      if (ordy === 1'b1 && ov === 1'b1) acc_cnt++;
      if (ol === 1'b1) lr_hi++;
      tick();
    end
  endtask

  logic [127:0] d, lr;
  int bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bclk_a, lr_a, data_a, fs_a, ready_a, und_a} !== 21'h0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d got=%h exp=0", i,
                 {bclk_a, lr_a, data_a, fs_a, ready_a, und_a});
      end
    end
    rst_a = 1'b0;
    tick();
    checks++;
    if (fs_a !== 1'b1) begin failures++; $display("FAIL post_reset_fs got=%b exp=1", fs_a); end
    checks++;
    if (ready_a !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", ready_a); end
    checks++;
    if (und_a !== 16'h0) begin failures++; $display("FAIL post_reset_underrun got=%h exp=0", und_a); end
    checks++;
    if (bclk_a !== 1'b0) begin failures++; $display("FAIL post_reset_bclk got=%b exp=0", bclk_a); end
  endtask

  task automatic test_data();
    sample_a = {24'hABCDEF, 24'h123456};
    valid_a  = 1'b1;
    capture(0, 64, {16'h0, sample_a}, 1'b0, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d[63:0] !== 64'h0) begin failures++; $display("FAIL first_frame_zero got=%h exp=0", d[63:0]); end
    checks++;
    if (acc_cnt !== 1) begin failures++; $display("FAIL first_accept got=%0d exp=1", acc_cnt); end
    capture(0, 64, {16'h0, sample_a}, 1'b0, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d[63:0] !== exp_i2s({24'hABCDEF, 24'h123456})) begin
      failures++;
      $display("FAIL i2s_data got=%h exp=%h", d[63:0], exp_i2s({24'hABCDEF, 24'h123456}));
    end
    checks++;
    if (lr[63:0] !== LR_I2S) begin failures++; $display("FAIL i2s_lrclk got=%h exp=%h", lr[63:0], LR_I2S); end
    checks++;
    if (lr_hi !== 192) begin failures++; $display("FAIL i2s_lrclk_high got=%0d exp=192", lr_hi); end
    checks++;
    if (bclk_err !== 0) begin failures++; $display("FAIL i2s_bclk_errors got=%0d exp=0", bclk_err); end
    checks++;
    if (fs_cnt !== 1) begin failures++; $display("FAIL i2s_fs_count got=%0d exp=1", fs_cnt); end
  endtask

  task automatic test_underrun();
    checks++;
    if (und_a !== 16'd1) begin failures++; $display("FAIL underrun_1 got=%0d exp=1", und_a); end
    capture(0, 64, {16'h0, sample_a}, 1'b0, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d[63:0] !== 64'h0) begin failures++; $display("FAIL underrun_frame1 got=%h exp=0", d[63:0]); end
    checks++;
    if (fs_cnt !== 1) begin failures++; $display("FAIL underrun_fs got=%0d exp=1", fs_cnt); end
    checks++;
    if (und_a !== 16'd2) begin failures++; $display("FAIL underrun_2 got=%0d exp=2", und_a); end
    capture(0, 64, {16'h0, sample_a}, 1'b0, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d[63:0] !== 64'h0) begin failures++; $display("FAIL underrun_frame2 got=%h exp=0", d[63:0]); end
  endtask

  task automatic test_back_to_back();
    checks++;
    if ({ready_a, fs_a} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_start ready/fs got=%b exp=11", {ready_a, fs_a});
    end
    sample_a = S1;
    valid_a  = 1'b1;
    capture(0, 64, {16'h0, S2}, 1'b1, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (acc_cnt !== 1 || rdy_cnt !== 1) begin
      failures++;
      $display("FAIL b2b_frame4 accepts=%0d ready_cycles=%0d exp=1/1", acc_cnt, rdy_cnt);
    end
    checks++;
    if (ready_a !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_load got=%b exp=1", ready_a); end
    capture(0, 64, {16'h0, S3}, 1'b1, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d[63:0] !== exp_i2s(S1)) begin failures++; $display("FAIL b2b_data_s1 got=%h exp=%h", d[63:0], exp_i2s(S1)); end
    checks++;
    if (acc_cnt !== 1 || rdy_cnt !== 1) begin
      failures++;
      $display("FAIL b2b_frame5 accepts=%0d ready_cycles=%0d exp=1/1", acc_cnt, rdy_cnt);
    end
    capture(0, 64, {16'h0, S3}, 1'b0, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d[63:0] !== exp_i2s(S2)) begin failures++; $display("FAIL b2b_data_s2 got=%h exp=%h", d[63:0], exp_i2s(S2)); end
    checks++;
    if (und_a !== 16'd3) begin failures++; $display("FAIL b2b_no_underrun got=%0d exp=3", und_a); end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 240; i++) tick();
    checks++;
    if ({lr_a, data_a} !== 2'b11) begin failures++; $display("FAIL pre_reset_b40 lr/data got=%b exp=11", {lr_a, data_a}); end
    rst_a = 1'b1;
    tick();
    checks++;
    if ({bclk_a, lr_a, data_a, fs_a, ready_a, und_a} !== 21'h0) begin
      failures++;
      $display("FAIL midframe_reset got=%h exp=0", {bclk_a, lr_a, data_a, fs_a, ready_a, und_a});
    end
    rst_a = 1'b0;
    tick();
    checks++;
    if ({fs_a, und_a} !== 17'h10000) begin
      failures++;
      $display("FAIL restart fs/underrun got=%h exp=10000", {fs_a, und_a});
    end
    capture(0, 64, {16'h0, S3}, 1'b0, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d[63:0] !== 64'h0 || lr[63:0] !== LR_I2S || bclk_err !== 0) begin
      failures++;
      $display("FAIL restart_frame data=%h lr=%h bclk_err=%0d exp=0/%h/0", d[63:0], lr[63:0], bclk_err, LR_I2S);
    end
    checks++;
    if (und_a !== 16'h0) begin failures++; $display("FAIL restart_underrun got=%0d exp=0", und_a); end
  endtask

  task automatic test_tdm();
    rst_b = 1'b0;
    tick();
    checks++;
    if ({fs_b, ready_b} !== 2'b11) begin failures++; $display("FAIL tdm_post_reset fs/ready got=%b exp=11", {fs_b, ready_b}); end
    sample_b = {16'hFFFF, 16'h0000, 16'h7FFF, 16'h8001};
    valid_b  = 1'b1;
    capture(1, 128, sample_b, 1'b0, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d !== 128'h0) begin failures++; $display("FAIL tdm_first_frame got=%h exp=0", d); end
    valid_b = 1'b1;
    mute_b  = 1'b1;
    capture(1, 128, sample_b, 1'b0, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d !== TDM_DATA) begin failures++; $display("FAIL tdm_data got=%h exp=%h", d, TDM_DATA); end
    checks++;
    if (lr !== LR_TDM || lr_hi !== 6) begin
      failures++;
      $display("FAIL tdm_sync got=%h high=%0d exp=%h high=6", lr, lr_hi, LR_TDM);
    end
    checks++;
    if (bclk_err !== 0 || fs_cnt !== 1) begin
      failures++;
      $display("FAIL tdm_timing bclk_err=%0d fs=%0d exp=0/1", bclk_err, fs_cnt);
    end
    checks++;
    if (und_b !== 16'h0) begin failures++; $display("FAIL tdm_mute_no_underrun got=%0d exp=0", und_b); end
    mute_b = 1'b0;
    capture(1, 128, sample_b, 1'b0, d, lr, bclk_err, fs_cnt, rdy_cnt, acc_cnt, lr_hi);
    checks++;
    if (d !== 128'h0) begin failures++; $display("FAIL tdm_muted_frame got=%h exp=0", d); end
    checks++;
    if (und_b !== 16'd1) begin failures++; $display("FAIL tdm_mute_consumed got=%0d exp=1", und_b); end
  endtask

  initial begin
    rst_a = 1'b1; valid_a = 1'b0; mute_a = 1'b0; sample_a = '0;
    rst_b = 1'b1; valid_b = 1'b0; mute_b = 1'b0; sample_b = '0;
    test_reset();
    test_data();
    test_underrun();
    test_back_to_back();
    test_midframe_reset();
    test_tdm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/i2s_tdm_transmitter.md
I2S_TDM_TRANSMITTER -- requirements
Module: i2s_tdm_transmitter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of audio slots per frame, legal range 1..16.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24: bits per sample, legal range 8..32.
REQ-003 SHALL have parameter SLOT_WIDTH, default 32: bit clocks per slot; SLOT_WIDTH >= SAMPLE_WIDTH.
REQ-004 SHALL have parameter BCLK_DIV, default 6: system clocks per bit clock, even, >= 2.
REQ-005 SHALL have parameter MODE, default 0: 0 = I2S, 1 = left-justified, 2 = TDM; modes 0/1 require CHANNELS == 2.
REQ-006 SHALL have port clock_16_934_400, input, 1 bit: sole clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port sample_in, input, CHANNELS*SAMPLE_WIDTH bits: two's-complement samples, channel 0 in the LSBs.
REQ-009 SHALL have port sample_valid, input, 1 bit: sample_in is valid.
REQ-010 SHALL have port sample_ready, output, 1 bit: the holding register can accept a sample.
REQ-011 SHALL have port mute, input, 1 bit: transmit zeros.
REQ-012 SHALL have port i2s_bit_clock, output, 1 bit: BCLK.
REQ-013 SHALL have port i2s_left_right_clock, output, 1 bit: LRCLK in modes 0/1, frame sync in mode 2.
REQ-014 SHALL have port i2s_data, output, 1 bit: serial data, MSB first.
REQ-015 SHALL have port frame_start, output, 1 bit: one-clock pulse when a frame is loaded.
REQ-016 SHALL have port underrun_count, output, 16 bits: saturating count of underrun frames.

Function
REQ-017 SHALL run divider div_cnt 0..BCLK_DIV-1; BCLK is 0 while div_cnt < BCLK_DIV/2, else 1; all data/LRCLK changes occur when div_cnt wraps to 0 (BCLK falling edge).
REQ-018 SHALL run bit index b 0..CHANNELS*SLOT_WIDTH-1, advancing at each div_cnt wrap and wrapping to 0; slot s = b / SLOT_WIDTH.
REQ-019 SHALL have a holding register (1 entry): accept when sample_valid && sample_ready; sample_ready = !holding_full.
REQ-020 SHALL, at every b wrap to 0 (frame load), copy holding into the shift frame, clear holding_full, and pulse frame_start in that same clock; a sample accepted in that same clock is held for the next frame.
REQ-021 SHALL, at frame load with holding empty and armed set, load an all-zero frame and increment underrun_count, saturating at 16'hFFFF; armed is set by the first accept after reset.
REQ-022 SHALL, with mute high at frame load, load an all-zero frame while still consuming the holding register.
REQ-023 SHALL left-align each sample in its slot; bits below SAMPLE_WIDTH within the slot are 0.
REQ-024 Mode 0 SHALL set LRCLK = (s == 1), with data delayed one BCLK: the slot MSB appears at slot bit 1, and the previous slot's LSB at slot bit 0 of the next slot or frame.
REQ-025 Mode 1 SHALL set LRCLK = (s == 0), with the slot MSB at slot bit 0 (no delay).
REQ-026 Mode 2 SHALL drive frame sync high only for b == 0, with the slot-0 MSB at b == 0 and slots contiguous.
REQ-027 SHALL keep the period at BCLK_DIV*CHANNELS*SLOT_WIDTH clocks (384 at defaults = 44.1 kHz); the period is independent of sample_valid.
REQ-028 SHALL ignore sample_valid during reset.

Reset
REQ-029 SHALL, while reset is high, hold div_cnt=0, b=0, BCLK=0, LRCLK=0 in all modes, i2s_data=0, frame_start=0, holding_full=0, armed=0, sample_ready=0, underrun_count=0, and the shift frame at 0.
REQ-030 SHALL, on the first clock after reset deasserts, assert sample_ready=1 and perform a frame load, with frame_start=1 and no underrun because armed is clear.
REQ-031 SHALL let a reset mid-frame abort the frame immediately with no partial-bit output.

Verification
REQ-032 Reset held for 3 clocks, defaults -> all outputs 0 during reset; first clock after reset: frame_start=1, sample_ready=1, underrun_count=0.
REQ-033 Defaults, accept L=24'h123456, R=24'hABCDEF -> next frame: BCLK period 6 clocks, LRCLK period 384 clocks; data reads 0x123456 from slot-0 bit 1, then 8 zeros, then 0xABCDEF from slot-1 bit 1.
REQ-034 Defaults, armed, no sample_valid for 2 frames -> two zero frames, underrun_count=2, frame_start still pulses every 384 clocks.
REQ-035 sample_valid held high continuously -> sample_ready drops after the accept and rises 1 clock after each frame load; exactly one accept per frame, no samples lost.
REQ-036 MODE=2, CHANNELS=4, SLOT_WIDTH=32, BCLK_DIV=6, SAMPLE_WIDTH=16, samples 16'h8001,16'h7FFF,16'h0000,16'hFFFF -> sync high for 6 clocks per 768-clock frame, slots contiguous and left-aligned; mute=1 at a frame load -> that frame all zeros.
REQ-037 Reset asserted at b=40 -> outputs 0 next clock; after release the frame restarts at b=0 with underrun_count=0.
